// File: rtl/sevenseg_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns (a..g, bit 6 = a),
// decimal-point bit position and the slot-phase state encoding.
package sevenseg_pkg;

  localparam int SEG_W  = 7;
  localparam int DP_BIT = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

  typedef enum logic [0:0] {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

endpackage

// File: rtl/sevenseg_decode.sv
// Hex nibble to a..g segment pattern (active high, bit 6 = segment a).
// Purely combinational, no backpressure.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0]       i_nibble,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = '0;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered, tear-free frames.
// seg/an lag the slot counter by one cycle; writer stalls (wr_ready=0) until the frame commits.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [4*NUM_DIGITS-1:0] i_wr_value,
  input  logic [NUM_DIGITS-1:0]   i_wr_dp,
  input  logic [NUM_DIGITS-1:0]   i_wr_blank,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DEAD_LAST_I = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_LAST_I);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam slot_state_e      ST_INIT   = (DEAD_CYCLES > 0) ? ST_DEAD : ST_DRIVE;

  logic [CNT_W-1:0]        r_slot_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  slot_state_e             r_state;
  slot_state_e             w_state_nxt;

  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pend_vld;
  logic [4*NUM_DIGITS-1:0] r_act_value;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;

  logic                    w_slot_wrap;
  logic                    w_idx_last;
  logic                    w_boundary;
  logic                    w_wr_fire;
  logic                    w_commit;
  logic [3:0]              w_cur_nibble;
  logic [SEG_W-1:0]        w_dec_seg;
  logic [7:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  assign w_slot_wrap  = (r_slot_cnt == CNT_LAST);
  assign w_idx_last   = (r_digit_idx == IDX_LAST);
  assign w_boundary   = i_enable & w_slot_wrap & w_idx_last;
  assign o_frame_tick = w_boundary;

  assign o_wr_ready = ~r_pend_vld;
  assign w_wr_fire  = i_wr_valid & o_wr_ready;
  // A disabled display cannot tear, so a pending frame may land without waiting for a boundary.
  assign w_commit   = r_pend_vld & (w_boundary | ~i_enable);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (!i_enable) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_wrap) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= w_idx_last ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_slot_cnt  <= r_slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_INIT;
    end else begin
      case (r_state)
        ST_DEAD:  if (r_slot_cnt == DEAD_LAST) w_state_nxt = ST_DRIVE;
        ST_DRIVE: if (w_slot_wrap && (DEAD_CYCLES > 0)) w_state_nxt = ST_DEAD;
        default:  w_state_nxt = ST_INIT;
      endcase
    end
  end

  assign w_cur_nibble = r_act_value[4*r_digit_idx +: 4];

  sevenseg_decode u_decode (
    .i_nibble (w_cur_nibble),
    .o_seg    (w_dec_seg)
  );

  always_comb begin
    w_seg_nxt = '0;
    w_an_nxt  = '1;
    if (i_enable && (r_state == ST_DRIVE) && !r_act_blank[r_digit_idx]) begin
      w_seg_nxt[SEG_W-1:0]  = w_dec_seg;
      w_seg_nxt[DP_BIT]     = r_act_dp[r_digit_idx];
      w_an_nxt[r_digit_idx] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg <= '0;
      o_an  <= '1;
    end else begin
      o_seg <= w_seg_nxt;
      o_an  <= w_an_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '1;
      r_pend_vld   <= 1'b0;
    end else if (w_wr_fire) begin
      r_pend_value <= i_wr_value;
      r_pend_dp    <= i_wr_dp;
      r_pend_blank <= i_wr_blank;
      r_pend_vld   <= 1'b1;
    end else if (w_commit) begin
      r_pend_vld   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act_value <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '1;
    end else if (w_commit) begin
      r_act_value <= r_pend_value;
      r_act_dp    <= r_pend_dp;
      r_act_blank <= r_pend_blank;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl at 4 digits, 8-cycle slots, 2 dead cycles.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_value;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int n_total = 0;
  int n_bad   = 0;
  int waited;

  // expected per-digit segment bytes {d3,d2,d1,d0}, hand-decoded
  localparam logic [31:0] SEGS_1234 = {8'h30, 8'h6D, 8'h79, 8'h33};
  localparam logic [31:0] SEGS_F0A9 = {8'h47, 8'h00, 8'h77, 8'hFB};

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .PRESCALE    (8),
    .DEAD_CYCLES (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_value   (wr_value),
    .i_wr_dp      (wr_dp),
    .i_wr_blank   (wr_blank),
    .o_seg        (seg),
    .o_an         (an),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input int limit, output int cnt);
    cnt = 0;
    while (frame_tick !== 1'b1 && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    if (frame_tick !== 1'b1) check("tick_timeout", {31'd0, frame_tick}, 32'd1);
  endtask

  // Called at the negedge of a boundary cycle; walks the following 32 cycles.
  task automatic check_frame(input string tag, input logic [31:0] segs,
                             input logic [3:0] lit, input logic exp_rdy1);
    for (int j = 1; j <= 32; j++) begin
      int         c;
      int         k;
      logic [3:0] ea;
      logic [7:0] es;
      @(negedge clk);
      wr_valid = 1'b0;
      if (j == 1) begin
        check({tag, "_rdy"}, {31'd0, wr_ready}, {31'd0, exp_rdy1});
      end else begin
        c = (j - 2) % 8;
        k = (j - 2) / 8;
        if (c < 2 || !lit[k]) begin
          ea = 4'hF;
          es = 8'h00;
        end else begin
          ea = ~(4'b0001 << k);
          es = segs[k*8 +: 8];
        end
        check({tag, "_out"}, {20'd0, an, seg}, {20'd0, ea, es});
      end
      check({tag, "_tick"}, {31'd0, frame_tick}, {31'd0, (j == 32)});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_value = 16'h0;
    wr_dp    = 4'h0;
    wr_blank = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_an",    {28'd0, an}, 32'hF);
    check("rst_seg",   {24'd0, seg}, 32'h0);
    check("rst_rdy",   {31'd0, wr_ready}, 32'd1);
    check("rst_tick",  {31'd0, frame_tick}, 32'd0);

    // idle scan with reset-blanked frame
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_tick(60, waited);
    check("first_tick", waited, 32'd31);
    check_frame("dark", 32'h0, 4'b0000, 1'b1);

    // write 1234, then a second write while not ready
    @(negedge clk);
    check("rdy_pre", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_value = 16'h1234;
    wr_dp    = 4'h0;
    wr_blank = 4'h0;
    @(negedge clk);
    check("rdy_drop", {31'd0, wr_ready}, 32'd0);
    wr_value = 16'h8888;
    wr_dp    = 4'hF;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    wait_tick(40, waited);
    check("tick_period", waited, 32'd28);
    check("rdy_hold", {31'd0, wr_ready}, 32'd0);
    check_frame("f1234", SEGS_1234, 4'b1111, 1'b1);

    // transfer exactly in the boundary cycle: old frame stays one more frame
    check("rdy_bnd", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_value = 16'hF0A9;
    wr_dp    = 4'b0001;
    wr_blank = 4'b0100;
    check_frame("old1234", SEGS_1234, 4'b1111, 1'b0);
    check_frame("fF0A9", SEGS_F0A9, 4'b1011, 1'b1);

    // enable dropped mid-slot with a pending frame
    repeat (12) @(negedge clk);
    check("pre_drop", {20'd0, an, seg}, {20'd0, 4'b1101, 8'h77});
    wr_valid = 1'b1;
    wr_value = 16'h5678;
    wr_dp    = 4'h0;
    wr_blank = 4'h0;
    @(negedge clk);
    wr_valid = 1'b0;
    enable   = 1'b0;
    check("drop_rdy0", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    check("drop_dark", {20'd0, an, seg}, {20'd0, 4'hF, 8'h00});
    check("drop_rdy1", {31'd0, wr_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("off_dark", {20'd0, an, seg}, {20'd0, 4'hF, 8'h00});
    check("off_tick", {31'd0, frame_tick}, 32'd0);

    // re-enable: dead gap, then digit 0 of the committed frame
    enable = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      case (j)
        1:  check("re_dead1", {20'd0, an, seg}, {20'd0, 4'hF, 8'h00});
        2:  check("re_dead2", {20'd0, an, seg}, {20'd0, 4'hF, 8'h00});
        3:  check("re_d0a",   {20'd0, an, seg}, {20'd0, 4'b1110, 8'h7F});
        8:  check("re_d0b",   {20'd0, an, seg}, {20'd0, 4'b1110, 8'h7F});
        9:  check("re_gap",   {20'd0, an, seg}, {20'd0, 4'hF, 8'h00});
        11: check("re_d1",    {20'd0, an, seg}, {20'd0, 4'b1101, 8'h70});
        default: ;
      endcase
    end
    wait_tick(40, waited);
    check("re_tick", waited, 32'd20);

    // reset asserted mid-frame with a pending frame
    @(negedge clk);
    check("rst2_rdy_pre", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_value = 16'h1111;
    @(negedge clk);
    wr_valid = 1'b0;
    check("rst2_rdy0", {31'd0, wr_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("pre_rst", {20'd0, an, seg}, {20'd0, 4'b1110, 8'h7F});
    rst_n = 1'b0;
    #1;
    check("arst_an",   {28'd0, an}, 32'hF);
    check("arst_seg",  {24'd0, seg}, 32'h0);
    check("arst_rdy",  {31'd0, wr_ready}, 32'd1);
    check("arst_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(60, waited);
    check("rst2_tick", waited, 32'd31);
    check_frame("post_rst", 32'h0, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
